// File: rtl/pio_arb_pkg.sv
// -----------------------------------------------------------------------------
// pio_arb_pkg
// Shared types and constants for the PIO write arbiter.
//   arb_state_t      : arbiter FSM states (IDLE, WRITE, DWELL)
//   PIO_ADDR_DATA    : PIO slave register address used for every write
//   PIO_DATA_W       : width of the PIO slave write-data bus
//   DWELL_CNT_W      : width of the dwell down-counter (covers DWELL 0..255)
//   dwell_load_value : counter preload for a given dwell length
// -----------------------------------------------------------------------------
package pio_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_DWELL = 2'd2
    } arb_state_t;

    localparam logic [1:0] PIO_ADDR_DATA = 2'd0;
    localparam int         PIO_DATA_W    = 32;
    localparam int         DWELL_CNT_W   = 8;

    // The counter is loaded on the WRITE->DWELL edge and the DWELL state is
    // left when it reads zero, so a preload of dwell-1 gives dwell cycles.
    function automatic logic [DWELL_CNT_W-1:0] dwell_load_value(input int dwell);
        if (dwell > 0) begin
            return DWELL_CNT_W'(dwell - 1);
        end
        return '0;
    endfunction

endpackage

// File: rtl/dwell_timer.sv
// -----------------------------------------------------------------------------
// dwell_timer
// Loadable down-counter that times the idle gap after each PIO write.
// Ports:
//   clk          : clock, rising edge
//   reset        : synchronous, active-high; clears the count
//   i_load       : load i_load_value into the counter
//   i_load_value : preload value
//   i_count      : decrement by one (saturates at zero)
//   o_zero       : counter currently reads zero
// -----------------------------------------------------------------------------
module dwell_timer
    import pio_arb_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_load,
    input  logic [DWELL_CNT_W-1:0] i_load_value,
    input  logic                   i_count,
    output logic                   o_zero
);

    logic [DWELL_CNT_W-1:0] r_count;

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples its inputs from before the edge, independent of block order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_value;
        end else if (i_count && (r_count != '0)) begin
            r_count <= r_count - DWELL_CNT_W'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/pio_write_arbiter.sv
// -----------------------------------------------------------------------------
// pio_write_arbiter
// Arbitrates two single-value write requesters onto one PIO slave port.
// A request seen in IDLE is granted (round-robin on ties), its data latched,
// and written in the following single WRITE cycle, which also pulses the
// requester's ack. An optional DWELL period of idle cycles follows each write.
// Parameters:
//   DATA_W : requester data width (at most 32, zero-extended onto the PIO bus)
//   DWELL  : idle cycles after each write, 0..255
// Ports:
//   clk, reset         : clock (rising edge), synchronous active-high reset
//   req0/req1          : write requests
//   data0/data1        : requested values
//   ack0/ack1          : one-cycle pulse, value written
//   pio_address        : PIO register address (always 0)
//   pio_chipselect     : PIO select, high only in WRITE
//   pio_write_n        : PIO write strobe, active-low, low only in WRITE
//   pio_writedata      : PIO write data, zero outside WRITE
//   busy               : FSM not in IDLE
// -----------------------------------------------------------------------------
module pio_write_arbiter
    import pio_arb_pkg::*;
#(
    parameter int DATA_W = 10,
    parameter int DWELL  = 4
)
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0,
    input  logic                  req1,
    input  logic [DATA_W-1:0]     data0,
    input  logic [DATA_W-1:0]     data1,
    output logic                  ack0,
    output logic                  ack1,
    output logic [1:0]            pio_address,
    output logic                  pio_chipselect,
    output logic                  pio_write_n,
    output logic [PIO_DATA_W-1:0] pio_writedata,
    output logic                  busy
);

    localparam logic [DWELL_CNT_W-1:0] DWELL_LOAD = dwell_load_value(DWELL);

    arb_state_t          r_state;
    arb_state_t          w_state_next;
    logic                r_grant;       // requester owning the current write
    logic                r_last_grant;  // requester that wrote last; loses the next tie
    logic [DATA_W-1:0]   r_data;

    logic                w_take;
    logic                w_grant_sel;
    logic                w_write_active;
    logic                w_timer_load;
    logic                w_timer_count;
    logic                w_timer_zero;

    dwell_timer u_dwell_timer (
        .clk          (clk),
        .reset        (reset),
        .i_load       (w_timer_load),
        .i_load_value (DWELL_LOAD),
        .i_count      (w_timer_count),
        .o_zero       (w_timer_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
            r_data       <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_take) begin
                r_grant <= w_grant_sel;
                r_data  <= w_grant_sel ? data1 : data0;
            end
            if (r_state == S_WRITE) begin
                r_last_grant <= r_grant;
            end
        end
    end

    // Strobe and ack are also masked while reset is high, so a write whose
    // cycle coincides with reset never reaches the slave or the requester.
    assign w_write_active = (r_state == S_WRITE) && !reset;

    // NOTE: every signal written here gets a default first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    always_comb begin
        w_state_next   = r_state;
        w_take         = 1'b0;
        w_grant_sel    = 1'b0;
        w_timer_load   = 1'b0;
        w_timer_count  = 1'b0;
        ack0           = 1'b0;
        ack1           = 1'b0;
        pio_address    = PIO_ADDR_DATA;
        pio_chipselect = 1'b0;
        pio_write_n    = 1'b1;
        pio_writedata  = '0;
        busy           = (r_state != S_IDLE);

        case (r_state)
            S_IDLE: begin
                if (req0 || req1) begin
                    w_take       = 1'b1;
                    // Single requester wins outright; on a tie the one that
                    // did not write last wins.
                    w_grant_sel  = (req0 && req1) ? ~r_last_grant : req1;
                    w_state_next = S_WRITE;
                end
            end
            S_WRITE: begin
                if (DWELL == 0) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_state_next = S_DWELL;
                    w_timer_load = 1'b1;
                end
            end
            S_DWELL: begin
                if (w_timer_zero) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_timer_count = 1'b1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase

        if (w_write_active) begin
            pio_chipselect = 1'b1;
            pio_write_n    = 1'b0;
            pio_writedata  = PIO_DATA_W'(r_data);
            ack0           = ~r_grant;
            ack1           = r_grant;
        end
    end

endmodule

// File: tb/tb_pio_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_pio_write_arbiter
// Drives one shared stimulus into two arbiters (DWELL=4 and DWELL=0) and
// compares every cycle against a per-instance reference model that tracks
// "pending write next cycle" and "earliest cycle a new grant may be sampled".
// -----------------------------------------------------------------------------
module tb_pio_write_arbiter;

    localparam int DATA_W  = 10;
    localparam int DWELL_A = 4;
    localparam int DWELL_B = 0;

    logic              clk   = 1'b0;
    logic              reset = 1'b1;
    logic              req0  = 1'b0;
    logic              req1  = 1'b0;
    logic [DATA_W-1:0] data0 = '0;
    logic [DATA_W-1:0] data1 = '0;

    logic        ack0_a, ack1_a, cs_a, wn_a, busy_a;
    logic [1:0]  addr_a;
    logic [31:0] wdata_a;
    logic        ack0_b, ack1_b, cs_b, wn_b, busy_b;
    logic [1:0]  addr_b;
    logic [31:0] wdata_b;

    always #5 clk = ~clk;

    pio_write_arbiter #(.DATA_W(DATA_W), .DWELL(DWELL_A)) u_dut_a (
        .clk(clk), .reset(reset), .req0(req0), .req1(req1),
        .data0(data0), .data1(data1), .ack0(ack0_a), .ack1(ack1_a),
        .pio_address(addr_a), .pio_chipselect(cs_a), .pio_write_n(wn_a),
        .pio_writedata(wdata_a), .busy(busy_a)
    );

    pio_write_arbiter #(.DATA_W(DATA_W), .DWELL(DWELL_B)) u_dut_b (
        .clk(clk), .reset(reset), .req0(req0), .req1(req1),
        .data0(data0), .data1(data1), .ack0(ack0_b), .ack1(ack1_b),
        .pio_address(addr_b), .pio_chipselect(cs_b), .pio_write_n(wn_b),
        .pio_writedata(wdata_b), .busy(busy_b)
    );

    // {chipselect, write_n, address, writedata, ack0, ack1, busy}
    logic [38:0] obs [2];
    assign obs[0] = {cs_a, wn_a, addr_a, wdata_a, ack0_a, ack1_a, busy_a};
    assign obs[1] = {cs_b, wn_b, addr_b, wdata_b, ack0_b, ack1_b, busy_b};

    // Reference model state, one slot per instance.
    int              dw      [2];
    bit              pend    [2];   // a write is due in the current cycle
    bit              pwho    [2];
    logic [DATA_W-1:0] pdata [2];
    bit              last    [2];
    int              free_at [2];   // first cycle a new request may be sampled
    int              cyc = 0;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [38:0] got, input logic [38:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [38:0] expected(input int i);
        logic bsy;
        bsy = (cyc < free_at[i]);
        if (pend[i] && !reset) begin
            return {1'b1, 1'b0, 2'b00, 32'(pdata[i]), !pwho[i], pwho[i], bsy};
        end
        return {1'b0, 1'b1, 2'b00, 32'h0, 1'b0, 1'b0, bsy};
    endfunction

    task automatic model_edge(input int i);
        bit w;
        if (reset) begin
            pend[i]    = 1'b0;
            last[i]    = 1'b1;
            free_at[i] = 0;
        end else begin
            pend[i] = 1'b0;
            if ((cyc >= free_at[i]) && (req0 || req1)) begin
                w          = (req0 && req1) ? !last[i] : req1;
                pend[i]    = 1'b1;
                pwho[i]    = w;
                pdata[i]   = w ? data1 : data0;
                last[i]    = w;
                free_at[i] = cyc + 2 + dw[i];
            end
        end
    endtask

    // One clock cycle: compare both instances mid-cycle, advance the model
    // at the rising edge, return at the next falling edge for new inputs.
    task automatic step();
        #1;
        check("dwell4_cycle", obs[0], expected(0));
        check("dwell0_cycle", obs[1], expected(1));
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        cyc++;
        @(negedge clk);
    endtask

    logic [31:0] sq [$];
    int          scyc [$];
    int          n;
    int          first_k;

    initial begin
        dw[0] = DWELL_A;
        dw[1] = DWELL_B;
        for (int i = 0; i < 2; i++) begin
            pend[i] = 1'b0; pwho[i] = 1'b0; pdata[i] = '0;
            last[i] = 1'b1; free_at[i] = 0;
        end
        @(negedge clk);

        // Two reset cycles, then a single req0 write.
        reset = 1'b1;
        repeat (2) step();
        reset = 1'b0;
        req0  = 1'b1;
        data0 = 10'h2A5;
        step();
        check("req034_wdata", {7'd0, wdata_a}, 39'h2A5);
        check("req034_ack",   {37'd0, ack0_a, ack1_a}, 39'd2);
        step();
        req0 = 1'b0;
        repeat (8) step();

        // Both requesters held: strict alternation starting with requester 0.
        reset = 1'b1;
        step();
        reset = 1'b0;
        req0 = 1'b1; req1 = 1'b1;
        data0 = 10'h001; data1 = 10'h002;
        repeat (26) begin
            if (cs_a) begin
                sq.push_back(wdata_a);
                scyc.push_back(cyc);
            end
            step();
        end
        for (int k = 0; k < 4; k++) begin
            logic [31:0] got;
            got = (k < sq.size()) ? sq[k] : 32'hFFFF_FFFF;
            check("req035_order", {7'd0, got}, (k % 2 == 0) ? 39'd1 : 39'd2);
        end
        for (int k = 0; k < 3; k++) begin
            int gap;
            gap = (k + 1 < scyc.size()) ? (scyc[k+1] - scyc[k]) : -1;
            check("req035_gap", 39'(gap), 39'd6);
        end

        // req1 alone with no dwell: a write every second cycle.
        reset = 1'b1;
        step();
        reset = 1'b0;
        req0 = 1'b0; req1 = 1'b1; data1 = 10'h3C3;
        n = 0;
        repeat (12) begin
            if (cs_b && ack1_b && !ack0_b) n++;
            step();
        end
        check("req036_strobes", 39'(n), 39'd6);

        // req1 arrives during the dwell after a req0 write.
        reset = 1'b1;
        req1  = 1'b0;
        step();
        reset = 1'b0;
        req0 = 1'b1; data0 = 10'h155;
        step();
        req0 = 1'b0;
        step();
        req1 = 1'b1; data1 = 10'h0AA;
        n = 0; first_k = -1;
        for (int k = 0; k < 8; k++) begin
            if (cs_a) begin
                n++;
                if (first_k < 0 && ack1_a) first_k = k;
            end
            step();
        end
        req1 = 1'b0;
        check("req037_count", 39'(n), 39'd1);
        check("req037_when", 39'(first_k), 39'd5);
        repeat (6) step();

        // Reset during the WRITE cycle aborts it; the following tie goes to 0.
        reset = 1'b1;
        step();
        reset = 1'b0;
        req0 = 1'b1; req1 = 1'b1;
        data0 = 10'h111; data1 = 10'h222;
        step();
        reset = 1'b1;
        #1;
        check("req038_nostrobe", {37'd0, cs_a, ack0_a | ack1_a}, 39'd0);
        step();
        reset = 1'b0;
        step();
        check("req038_tie_ack",  {37'd0, ack0_a, ack1_a}, 39'd2);
        check("req038_tie_data", {7'd0, wdata_a}, 39'h111);
        req0 = 1'b0; req1 = 1'b0;
        repeat (8) step();

        // req0 dropped right after it is sampled: write still completes.
        req0 = 1'b1; data0 = 10'h3FF;
        step();
        req0 = 1'b0;
        check("req039_ack",  {37'd0, ack0_a, ack1_a}, 39'd2);
        check("req039_data", {7'd0, wdata_a}, 39'h3FF);
        repeat (8) step();

        // Randomized traffic with occasional resets.
        repeat (600) begin
            reset = ($urandom_range(0, 59) == 0);
            req0  = ($urandom_range(0, 1) == 1);
            req1  = ($urandom_range(0, 1) == 1);
            data0 = DATA_W'($urandom);
            data1 = DATA_W'($urandom);
            step();
        end

        reset = 1'b0; req0 = 1'b0; req1 = 1'b0;
        repeat (8) step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pio_write_arbiter.md
PIO_WRITE_ARBITER -- requirements
Module: pio_write_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 10, meaning the width of the parallel output port data being written.
REQ-002 The block SHALL have parameter DWELL, default 4, meaning the minimum number of idle cycles after each write (range 0..255).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, with every flop on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: the reset, which is synchronous and active-high.
REQ-005 The block SHALL have ports req0/req1, input, 1 bit each: a write request from requester 0/1.
REQ-006 The block SHALL have ports data0/data1, input, DATA_W bits each: the value requested by requester 0/1.
REQ-007 The block SHALL have ports ack0/ack1, output, 1 bit each: a one-cycle pulse meaning the requested value is written.
REQ-008 The block SHALL have port pio_address, output, 2 bits: the PIO slave register address.
REQ-009 The block SHALL have port pio_chipselect, output, 1 bit: the PIO slave select.
REQ-010 The block SHALL have port pio_write_n, output, 1 bit: the PIO slave write strobe, active-low.
REQ-011 The block SHALL have port pio_writedata, output, 32 bits: the PIO slave write data.
REQ-012 The block SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, WRITE and DWELL.
REQ-014 In IDLE with exactly one req high, the block SHALL grant that requester, latch its data and move to WRITE.
REQ-015 In IDLE with both req high, the block SHALL grant the requester not granted last (round-robin).
REQ-016 The last_grant flag SHALL be 1 after reset, so requester 0 wins the first tie.
REQ-017 In IDLE with no req high, the FSM SHALL remain in IDLE with no outputs active.
REQ-018 WRITE SHALL last exactly one cycle, in which the block drives pio_chipselect=1, pio_write_n=0, pio_address=0 and pio_writedata = latched data zero-extended to 32 bits.
REQ-019 During the WRITE cycle the block SHALL pulse ack of the granted requester only, and SHALL update last_grant.
REQ-020 Outside WRITE the block SHALL drive pio_chipselect=0, pio_write_n=1, pio_address=0, pio_writedata=0 and both acks 0.
REQ-021 If a req is sampled in IDLE at cycle N, the write strobe and ack SHALL occur in cycle N+1.
REQ-022 After WRITE, if DWELL>0 the FSM SHALL enter DWELL, load a down-counter with DWELL-1, and return to IDLE when the counter reaches 0 (exactly DWELL cycles in DWELL).
REQ-023 After WRITE, if DWELL=0 the FSM SHALL return directly to IDLE.
REQ-024 The earliest next grant SHALL be sampled at cycle N+2+DWELL.
REQ-025 A requester SHALL hold req and data stable until its ack; a req still high in the cycle after ack SHALL be treated as a new request.
REQ-026 If a req drops after grant but before ack, the latched write SHALL still complete and ack SHALL still pulse.
REQ-027 Requests arriving during WRITE or DWELL SHALL be ignored until IDLE, with no queueing beyond req level.
REQ-028 data bits above DATA_W SHALL not exist, and pio_writedata[31:DATA_W] SHALL always be 0.

Reset
REQ-029 While reset is high at a clk edge, the FSM SHALL go to IDLE, the counter to 0, the latched data to 0 and last_grant to 1.
REQ-030 Reset asserted in WRITE or DWELL SHALL abort the operation: no strobe and no ack in the cycle after the reset edge.
REQ-031 All outputs SHALL take their REQ-020 values and busy SHALL be 0 from the first edge with reset high.

Structure
REQ-032 The state enum and the PIO address constant (0) SHALL live in a shared package, pio_arb_pkg.
REQ-033 The dwell counter SHALL be a sub-module, dwell_timer (load, count, zero flag).

Verification
REQ-034 With reset high for 2 cycles, then req0=1 and data0=10'h2A5: strobe occurs 1 cycle later with writedata=32'h000002A5 and ack0=1, ack1=0.
REQ-035 With req0 and req1 held high, data0=10'h001 and data1=10'h002, DWELL=4: writes alternate 1,2,1,2 with strobes 6 cycles apart.
REQ-036 With DWELL=0 and req1 held high: strobes occur every 2 cycles, each with ack1.
REQ-037 With req1 raised during DWELL after a req0 write: no strobe until IDLE, then the req1 write happens.
REQ-038 With reset asserted in the WRITE-entry cycle (the cycle after grant): no strobe and no ack; after release, a tie grants requester 0.
REQ-039 With req0 dropped the cycle after it is sampled: the write still completes and ack0 pulses.
